// File: rtl/newhope_pkg.sv
// Constants shared by the NewHope polynomial datapath (sampler, pointwise MAC, NTT).
// The FSM state type for the pointwise multiply-accumulate lives here too.
package newhope_pkg;
  localparam int N         = 512;
  localparam int ADDR_W    = 9;
  localparam int Q         = 12289;
  localparam int BARRETT_M = 349496;
  localparam int COEF_W    = 16;
  localparam int X_W       = 30;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } mac_state_t;
endpackage

// File: rtl/barrett_reduce.sv
// Three-stage Barrett reducer: x < 2^30 -> x mod Q, with a valid bit and tag
// travelling alongside. Output data and tag read as zero whenever out_valid is low.
module barrett_reduce
  import newhope_pkg::*;
#(
  parameter int TAG_W = ADDR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [X_W-1:0]   x,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic [13:0]      r
);
  localparam logic [14:0] Q15 = 15'(Q);

  logic [48:0]      prod;
  logic [14:0]      x1_reg;
  logic [14:0]      t1_reg;
  logic [14:0]      r2_reg;
  logic [14:0]      r_sub;
  logic [2:0]       valid_reg;
  logic [TAG_W-1:0] tag_reg [3];
  logic [13:0]      r3_reg;
  logic             unused_bits;

  // The true remainder x - t*Q is below 2Q < 2^15, so the subtraction can be
  // done modulo 2^15 using only the low 15 bits of x and t.
  assign prod  = 49'(x) * 49'(BARRETT_M);
  assign r_sub = r2_reg - Q15;
  assign unused_bits = ^{prod[48:47], prod[31:0], x[X_W-1:15], r_sub[14]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_reg <= '0;
      x1_reg    <= '0;
      t1_reg    <= '0;
      r2_reg    <= '0;
      r3_reg    <= '0;
      for (int i = 0; i < 3; i++) tag_reg[i] <= '0;
    end else begin
      valid_reg <= {valid_reg[1:0], in_valid};
      x1_reg    <= x[14:0];
      t1_reg    <= prod[46:32];
      tag_reg[0] <= in_tag;
      r2_reg    <= x1_reg - t1_reg * Q15;
      tag_reg[1] <= tag_reg[0];
      if (valid_reg[1]) begin
        r3_reg     <= (r2_reg >= Q15) ? r_sub[13:0] : r2_reg[13:0];
        tag_reg[2] <= tag_reg[1];
      end else begin
        r3_reg     <= '0;
        tag_reg[2] <= '0;
      end
    end
  end

  assign out_valid = valid_reg[2];
  assign out_tag   = tag_reg[2];
  assign r         = r3_reg;
endmodule

// File: rtl/poly_pointwise_mac.sv
// Streams b = a*s + e mod Q over N coefficients, one per clock, from three
// lockstep source RAMs into the output RAM; done pulses as the FSM returns to IDLE.
module poly_pointwise_mac
  import newhope_pkg::*;
#(
  parameter int N      = newhope_pkg::N,
  parameter int ADDR_W = newhope_pkg::ADDR_W,
  parameter int Q      = newhope_pkg::Q
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              done,
  output logic [ADDR_W-1:0] coef_addr,
  input  logic [15:0]       a_do,
  input  logic [15:0]       s_do,
  input  logic [15:0]       e_do,
  output logic              b_wea,
  output logic [ADDR_W-1:0] b_addra,
  output logic [15:0]       b_dia
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

  mac_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              done_reg, done_next;

  logic              rd_valid_reg;
  logic [ADDR_W-1:0] rd_addr_reg;
  logic              x_valid_reg;
  logic [ADDR_W-1:0] x_addr_reg;
  logic [X_W-1:0]    x_reg;

  logic              red_valid;
  logic [ADDR_W-1:0] red_tag;
  logic [13:0]       red_r;
  logic              unused_bits;

  assign unused_bits = ^{s_do[15:14], e_do[15:14]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      addr_reg  <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    done_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_RUN;
          addr_next  = '0;
        end
      end
      ST_RUN: begin
        if (addr_reg == LAST_ADDR) state_next = ST_DRAIN;
        else                       addr_next  = addr_reg + 1'b1;
      end
      ST_DRAIN: begin
        // The final coefficient is on the write port this cycle.
        if (red_valid && red_tag == LAST_ADDR) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // RAM read latency stage, then the P1 multiply-add.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_valid_reg <= 1'b0;
      rd_addr_reg  <= '0;
      x_valid_reg  <= 1'b0;
      x_addr_reg   <= '0;
      x_reg        <= '0;
    end else begin
      rd_valid_reg <= (state_reg == ST_RUN);
      rd_addr_reg  <= addr_reg;
      x_valid_reg  <= rd_valid_reg;
      x_addr_reg   <= rd_addr_reg;
      x_reg        <= X_W'(a_do) * X_W'(s_do[13:0]) + X_W'(e_do[13:0]);
    end
  end

  barrett_reduce #(.TAG_W(ADDR_W)) u_reduce (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (x_valid_reg),
    .in_tag    (x_addr_reg),
    .x         (x_reg),
    .out_valid (red_valid),
    .out_tag   (red_tag),
    .r         (red_r)
  );

  assign done      = done_reg;
  assign coef_addr = addr_reg;
  assign b_wea     = red_valid;
  assign b_addra   = red_tag;
  assign b_dia     = {2'b00, red_r};
endmodule

// File: tb/tb_poly_pointwise_mac.sv
// Directed and random passes through poly_pointwise_mac with cycle-exact
// checks of the write port and done pulse against bench-computed values.
module tb_poly_pointwise_mac;
  localparam int N = 512;
  localparam int Q = 12289;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        done;
  logic [8:0]  coef_addr;
  logic [15:0] a_do, s_do, e_do;
  logic        b_wea;
  logic [8:0]  b_addra;
  logic [15:0] b_dia;

  logic [15:0] a_mem [N];
  logic [15:0] s_mem [N];
  logic [15:0] e_mem [N];
  logic [15:0] exp_mem [N];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  poly_pointwise_mac dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .done      (done),
    .coef_addr (coef_addr),
    .a_do      (a_do),
    .s_do      (s_do),
    .e_do      (e_do),
    .b_wea     (b_wea),
    .b_addra   (b_addra),
    .b_dia     (b_dia)
  );

  // Source RAMs with one-cycle registered read.
  always @(posedge clk) begin
    a_do <= a_mem[coef_addr];
    s_do <= s_mem[coef_addr];
    e_do <= e_mem[coef_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests++;
    assert (got === want)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic fill_const(input logic [15:0] a, input logic [15:0] s,
                            input logic [15:0] e, input logic [15:0] b);
    for (int i = 0; i < N; i++) begin
      a_mem[i] = a; s_mem[i] = s; e_mem[i] = e; exp_mem[i] = b;
    end
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < N; i++) begin
      a_mem[i] = 16'(i); s_mem[i] = 16'd1; e_mem[i] = 16'd0; exp_mem[i] = 16'(i);
    end
  endtask

  // One pass: cycle k after the start edge T0 must show write k-5 for
  // k in [5, N+4] and the done pulse alone at k = N+5.
  task automatic run_pass(input bit chained, input bit hold, input string tag);
    logic [26:0] want;
    if (!chained) begin
      @(negedge clk);
      start = 1'b1;
    end
    @(posedge clk);
    #1;
    start = hold;
    check($sformatf("%s addr0", tag), 64'(coef_addr), 64'd0);
    for (int k = 1; k <= N + 5; k++) begin
      @(posedge clk);
      #1;
      if (k >= 5 && k <= N + 4)
        want = {1'b0, 1'b1, 9'(k - 5), exp_mem[k - 5]};
      else if (k == N + 5)
        want = {1'b1, 1'b0, 9'd0, 16'd0};
      else
        want = '0;
      check($sformatf("%s k=%0d {done,wea,addr,dia}", tag, k),
            64'({done, b_wea, b_addra, b_dia}), 64'(want));
    end
    if (hold) start = 1'b0;
  endtask

  task automatic check_quiet(input int cycles, input string tag);
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s quiet %0d", tag, k), 64'({done, b_wea, b_addra, b_dia}), 64'd0);
    end
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    fill_const(16'd0, 16'd0, 16'd0, 16'd0);
    repeat (3) @(posedge clk);
    #1;
    check("reset done",      64'(done),      64'd0);
    check("reset coef_addr", 64'(coef_addr), 64'd0);
    check("reset b_wea",     64'(b_wea),     64'd0);
    check("reset b_addra",   64'(b_addra),   64'd0);
    check("reset b_dia",     64'(b_dia),     64'd0);
    rst = 1'b1;
    check_quiet(3, "post_reset");

    // x = 12288*61445 = 5*12288*Q: largest multiple-of-Q case, b = 0.
    fill_const(16'd61444, 16'd12288, 16'd12288, 16'd0);
    run_pass(1'b0, 1'b0, "maxx");

    // Ramp with start held through the whole pass: one pass only.
    fill_ramp();
    run_pass(1'b0, 1'b1, "ramp_hold");
    check_quiet(10, "after_hold");

    // a = Q: b = e = 7. Then a back-to-back pass started in the done cycle.
    fill_const(16'd12289, 16'd5, 16'd7, 16'd7);
    run_pass(1'b0, 1'b0, "q_s5_e7");
    start = 1'b1;
    // (65535*16383 + 16383) mod 12289 = 10936
    fill_const(16'd65535, 16'd16383, 16'd16383, 16'd10936);
    run_pass(1'b1, 1'b0, "max16");
    check_quiet(3, "after_max16");

    // Reset while coef_addr = 100, then a fresh pass.
    fill_ramp();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("midrst coef_addr", 64'(coef_addr), 64'd100);
    check("midrst b_wea before", 64'(b_wea), 64'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("midrst {done,wea,addr,dia}", 64'({done, b_wea, b_addra, b_dia}), 64'd0);
    check("midrst coef_addr zero", 64'(coef_addr), 64'd0);
    check_quiet(20, "midrst");
    run_pass(1'b0, 1'b0, "after_rst");

    // Random passes against an independent modular model.
    for (int p = 0; p < 20; p++) begin
      for (int i = 0; i < N; i++) begin
        longint unsigned x;
        a_mem[i] = 16'($urandom_range(0, 5 * Q - 1));
        s_mem[i] = 16'($urandom_range(0, Q - 1));
        e_mem[i] = 16'($urandom_range(0, Q - 1));
        x = longint'(a_mem[i]) * longint'(s_mem[i]) + longint'(e_mem[i]);
        exp_mem[i] = 16'(x % longint'(Q));
      end
      run_pass(1'b0, 1'b0, $sformatf("rand%0d", p));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/poly_pointwise_mac.md
# poly_pointwise_mac

Computes b = a∘s + e mod q coefficient-wise over N-coefficient NewHope polynomials, one coefficient per clock. Sits directly downstream of the uniform sampler that fills the a-polynomial RAM with SHAKE-derived coefficients below 5q. It reads the a, s and e RAMs in lockstep and writes fully reduced b coefficients, in [0, q), to the output RAM. Fully pipelined: N + 5 cycles from start to done.

## Interface
Parameters:
- N, 512, coefficients per polynomial
- ADDR_W, 9, RAM address width (log2 N)
- Q, 12289, modulus

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset: one clock, reset is synchronous and active-low (rst = 0 resets on the next clk edge)
- start  in  1  begin one pass; sampled only in IDLE
- done  out  1  one-cycle pulse after the final write
- coef_addr  out  ADDR_W  shared read address for the a, s and e RAMs
- a_do  in  16  a coefficient (sampler output, < 5q; any 16-bit value handled)
- s_do  in  16  secret coefficient, < q
- e_do  in  16  error coefficient, < q
- b_wea  out  1  output RAM write enable
- b_addra  out  ADDR_W  output RAM write address
- b_dia  out  16  output coefficient, always < Q

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE → RUN when start = 1.
  - RUN → DRAIN after coef_addr = N−1 has been issued.
  - DRAIN → IDLE on the cycle the last write retires; done = 1 on that transition.
- start while in RUN or DRAIN is ignored. No queuing.
- In RUN, coef_addr is registered and increments by 1 per cycle from 0 to N−1. It never wraps within a pass.
- All three source RAMs have a 1-cycle registered read.
- Pipeline (one register per stage):
  - P1: x = a·s + e, 30-bit unsigned.
  - P2: t = (x · BARRETT_M) >> 32, with BARRETT_M = 349496.
  - P3: r = x − t·Q. r is always in [0, 2Q) and is held in 15 bits.
  - P4: b = (r ≥ Q) ? r − Q : r; write to the output RAM.
- Range rule: result is exact for any 16-bit a and any s, e ≤ 16383, because x < 2^30. Bits [15:14] of s_do and e_do are ignored.
- A valid bit and an address travel alongside each pipeline stage. b_addra is the delayed coef_addr.
- When b_wea = 0: b_addra = 0 and b_dia = 0.
- Reset values: state IDLE, done 0, coef_addr 0, b_wea 0, b_addra 0, b_dia 0. All pipeline valid bits are cleared.
- Reset mid-pass: the next edge returns to IDLE and clears all valid bits. No further writes occur, and done is not pulsed. A subsequent start performs a complete fresh pass.

## Timing
- Let T0 be the edge at which start is sampled in IDLE.
- At T0, coef_addr becomes 0 and the state becomes RUN.
- b[i] is written during the cycle after edge T0+5+i: b_wea = 1, b_addra = i.
- Writes are contiguous, one per cycle, with no gaps. Throughput is 1 coefficient per clock.
- The last write (i = N−1) is active after edge T0+N+4.
- done is high for exactly one cycle after edge T0+N+5 (T0+517 for N = 512). The FSM is in IDLE in that same cycle.
- A start asserted in the done cycle is accepted; the next pass begins immediately.
- No backpressure: the source RAMs must be stable and exclusively owned by this block from T0 to done.

## Structure
- Shared package newhope_pkg holds N, Q, ADDR_W, BARRETT_M = 349496 and the coefficient width of 16. The upstream sampler uses the same constants (5Q bound).
- Sub-module barrett_reduce: a 3-stage pipelined reducer, x[29:0] → r[13:0] < Q. It has in_valid/out_valid and carries an address tag. It is reused by later NTT stages.
- Top level: the FSM, the address counter, the P1 multiply-add, and the valid/address delay line.

## Test plan
- a[i] = 61444, s[i] = 12288, e[i] = 12288 for all i → every b[i] = 0. Checks max-range x with no overflow.
- a[i] = i, s[i] = 1, e[i] = 0 → b[i] = i for i = 0..511. Writes in address order; done exactly 517 cycles after the start edge.
- a = 12289, s = 5, e = 7 everywhere → b = 7. a = 65535, s = 16383, e = 16383 → b = (65535·16383 + 16383) mod 12289.
- start held high for the entire pass → exactly one pass and one done pulse. Pulse start in the done cycle → a second pass starts with no idle gap.
- Assert rst = 0 when coef_addr = 100 → no b_wea after the reset edge, done stays 0, all outputs 0. A new start then rewrites all 512 values correctly.
- 20 random passes with a < 5q and s, e < q, compared against a software model of (a·s + e) mod q → all 512 coefficients match and all b_dia < 12289.
